control_unit: RTL and testbench
===============================

Name:
control_unit

Overview:
- Main decoder of the KGP-RISC single-issue datapath.
- Takes the 4-bit instruction opcode and produces the datapath steering strobes: register write, memory read/write, write-back mux, register-branch select, ALU operand select and destination-register select.
- Outputs are registered: one clock of latency, so they line up with the following pipeline/stage register.
- Also flags opcodes that are not defined.

Parameters:
- OPW, 4, opcode width in bits. Only the value 4 is supported; the decode table below assumes it.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- opcode  input  4  instruction opcode field.
- RegWrite  output  1  1 = write result to register file.
- MemRead  output  1  1 = data-memory read.
- MemWrite  output  1  1 = data-memory write.
- MemtoReg  output  1  1 = write-back data from memory; 0 = from ALU.
- regbranch  output  1  1 = branch target taken from a register.
- AluSrc  output  1  1 = ALU operand B is the sign-extended immediate; 0 = register.
- RegDst  output  1  1 = destination from the R-format field; 0 = from the I-format field.
- illegal  output  1  1 = opcode not in the decode table.

Behaviour:
- While rst_n = 0, all eight outputs are forced to 0 immediately, independent of clk. This is the asynchronous clear.
- On rst_n deassertion, outputs hold 0 until the first rising clk edge.
- On each rising clk edge with rst_n = 1, every output is loaded from the combinational decode of the opcode sampled at that edge.
- Latency is exactly 1 cycle. Outputs are stable for the whole following cycle, with no glitches between edges.
- Decode table, listed as RegWrite, MemRead, MemWrite, MemtoReg, regbranch, AluSrc, RegDst, illegal:
  - 0000 R-type ALU (add/comp/and/xor/shift-by-reg): 1,0,0,0,0,0,1,0
  - 0001 immediate ALU (addi/compi/shift-by-imm): 1,0,0,0,0,1,0,0
  - 0010 load word: 1,1,0,1,0,1,0,0
  - 0011 store word: 0,0,1,0,0,1,0,0
  - 0100 register branch (br): 0,0,0,0,1,0,0,0
  - 0101 PC-relative/conditional branch: 0,0,0,0,0,0,0,0
  - 0110 branch-and-link (link written through the I-format destination path): 1,0,0,0,0,0,0,0
  - 0111 to 1111: 0,0,0,0,0,0,0,1
- An X or Z on any opcode bit at the sampling edge is treated as undefined: the outputs for that cycle are loaded as the illegal row.
- Invariants that hold in every cycle:
  - MemRead and MemWrite are never both 1.
  - MemtoReg = 1 implies MemRead = 1 and RegWrite = 1.
  - illegal = 1 implies all other outputs are 0.
- If reset is asserted in the middle of a cycle, the outputs clear at once. The opcode present at that time is discarded and not replayed.
- A new opcode applied in every cycle produces a new decode in every cycle. The block holds no other state.

Test Plan:
- Reset: hold rst_n = 0 with opcode = 0010 and toggle clk -> all outputs stay 0. Release rst_n -> after the first edge, RegWrite = 1, MemRead = 1, MemtoReg = 1, AluSrc = 1, all others 0.
- Opcode sweep 0000 through 0110, one opcode per cycle -> each row matches the table exactly 1 cycle later. Examples:
  - 0000 gives RegWrite = 1, RegDst = 1.
  - 0011 gives MemWrite = 1, AluSrc = 1.
  - 0100 gives regbranch = 1 only.
- Illegal range: sweep 0111 through 1111 -> illegal = 1 and the other 7 outputs = 0 on each.
- Asynchronous reset mid-cycle: with opcode = 0000 latched, pull rst_n low between edges -> RegWrite and RegDst fall to 0 before the next edge.
- Back-to-back load then store (0010, 0011) -> MemRead goes 1 then 0 while MemWrite goes 0 then 1 on consecutive cycles. The two are never both 1.
- Hold opcode = 0101 for 5 cycles -> all outputs remain 0 and illegal = 0 throughout.

Source files
------------

// File: rtl/control_unit.sv
// KGP-RISC main decoder: the opcode is turned into datapath steering strobes,
// and these outputs are registered so they line up with the next stage register.
module control_unit #(
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   output logic           RegWrite,
   output logic           MemRead,
   output logic           MemWrite,
   output logic           MemtoReg,
   output logic           regbranch,
   output logic           AluSrc,
   output logic           RegDst,
   output logic           illegal
);

   // Bit order: RegWrite, MemRead, MemWrite, MemtoReg, regbranch, AluSrc, RegDst, illegal
   logic [7:0] decodeNext;
   logic [7:0] decodeReg;

   // Opcodes carrying X/Z match no item, so they fall through to the illegal row.
   always_comb begin
      decodeNext = 8'b0000_0001;
      case (opcode)
         4'b0000: decodeNext = 8'b1000_0010;
         4'b0001: decodeNext = 8'b1000_0100;
         4'b0010: decodeNext = 8'b1101_0100;
         4'b0011: decodeNext = 8'b0010_0100;
         4'b0100: decodeNext = 8'b0000_1000;
         4'b0101: decodeNext = 8'b0000_0000;
         4'b0110: decodeNext = 8'b1000_0000;
         default: decodeNext = 8'b0000_0001;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decodeReg <= '0;
      end else begin
         decodeReg <= decodeNext;
      end
   end

   assign {RegWrite, MemRead, MemWrite, MemtoReg,
           regbranch, AluSrc, RegDst, illegal} = decodeReg;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed decode rows, checked on the falling edge.
module tb_control_unit;

   logic       clk;
   logic       rst_n;
   logic [3:0] opcode;
   logic       RegWrite, MemRead, MemWrite, MemtoReg;
   logic       regbranch, AluSrc, RegDst, illegal;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Expected rows: RegWrite, MemRead, MemWrite, MemtoReg, regbranch, AluSrc, RegDst, illegal
   logic [7:0] rowTbl [0:15];

   control_unit #(.OPW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .RegWrite  (RegWrite),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .MemtoReg  (MemtoReg),
      .regbranch (regbranch),
      .AluSrc    (AluSrc),
      .RegDst    (RegDst),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {RegWrite, MemRead, MemWrite, MemtoReg, regbranch, AluSrc, RegDst, illegal};
   endfunction

   task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkRow(input string tag, input logic [7:0] exp);
      logic [7:0] o;
      o = outs();
      checkVal(tag, o, exp);
      checkVal({tag, "_memExcl"}, {7'd0, o[6] & o[5]}, 8'd0);
      checkVal({tag, "_memtoReg"}, {7'd0, o[4] & ~(o[6] & o[7])}, 8'd0);
      checkVal({tag, "_illClean"}, {7'd0, o[0] & (o[7:1] != 7'd0)}, 8'd0);
   endtask

   initial begin
      rowTbl[0] = 8'b1000_0010;
      rowTbl[1] = 8'b1000_0100;
      rowTbl[2] = 8'b1101_0100;
      rowTbl[3] = 8'b0010_0100;
      rowTbl[4] = 8'b0000_1000;
      rowTbl[5] = 8'b0000_0000;
      rowTbl[6] = 8'b1000_0000;
      for (int i = 7; i < 16; i++) rowTbl[i] = 8'b0000_0001;

      // Reset held with a load opcode present
      rst_n  = 1'b0;
      opcode = 4'b0010;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         checkVal("rstHold", outs(), 8'd0);
      end
      #2 rst_n = 1'b1;
      #1 checkVal("rstRelPre", outs(), 8'd0);
      @(negedge clk);
      checkRow("rstRelLoad", 8'b1101_0100);

      // Legal opcode sweep, one per cycle
      for (int unsigned i = 0; i < 7; i++) begin
         opcode = i[3:0];
         @(negedge clk);
         checkRow($sformatf("sweep%0d", i), rowTbl[i]);
      end

      // Illegal range
      for (int unsigned i = 7; i < 16; i++) begin
         opcode = i[3:0];
         @(negedge clk);
         checkRow($sformatf("illegal%0d", i), 8'b0000_0001);
      end

      // Asynchronous reset mid-cycle with R-type latched
      opcode = 4'b0000;
      @(negedge clk);
      checkRow("rtypeLatched", 8'b1000_0010);
      #2 rst_n = 1'b0;
      #1 checkVal("asyncClear", outs(), 8'd0);
      @(posedge clk);
      #1 checkVal("asyncHeld", outs(), 8'd0);

      // Release, then back-to-back load and store
      @(negedge clk);
      rst_n  = 1'b1;
      opcode = 4'b0010;
      @(negedge clk);
      checkRow("b2bLoad", 8'b1101_0100);
      opcode = 4'b0011;
      @(negedge clk);
      checkRow("b2bStore", 8'b0010_0100);

      // Hold conditional branch for five cycles
      opcode = 4'b0101;
      repeat (5) begin
         @(negedge clk);
         checkRow("hold0101", 8'b0000_0000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
